// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and register indices for the pipeline hazard controller.
// Purely declarative: no logic, no latency, no flow control.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RK_BRANCH    = 2'd0,
    RK_EXCEPTION = 2'd1,
    RK_ERET      = 2'd2,
    RK_TIMEOUT   = 2'd3
  } redirect_kind_t;

  localparam int NUM_REGS  = 4;
  localparam int REG_IFID  = 0;
  localparam int REG_IDEX  = 1;
  localparam int REG_EXMEM = 2;
  localparam int REG_MEMWB = 3;

  // Counter width able to hold values 0..v-1, never narrower than one bit.
  function automatic int width_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_wait_timer.sv
// Counts consecutive memory-wait cycles; expired is high on the last permitted cycle.
// Zero-cycle output from the count register; LIMIT of 0 disables it entirely.
module wait_timer #(
  parameter int LIMIT = 256,
  parameter int WIDTH = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (LIMIT > 0) && (cnt != LAST)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign expired = (LIMIT > 0) && (cnt == LAST);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Turns hazard/event requests into per-register hold/nullify controls and PC redirects.
// Outputs are combinational from state and requests; DRAIN ignores every request.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 256,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_use_hazard,
  input  logic                mdu_busy,
  input  logic                mdu_use,
  input  logic                mem_wait,
  input  logic                branch_redirect,
  input  logic                exception_req,
  input  logic                eret_req,
  output logic [NUM_REGS-1:0] stall,
  output logic [NUM_REGS-1:0] bubble,
  output logic [NUM_REGS-1:0] nullify,
  output logic [NUM_REGS-1:0] keep_exception,
  output logic                pc_stall,
  output logic                redirect_valid,
  output logic [1:0]          redirect_kind,
  output logic                timeout_exc
);

  localparam int TW = width_min1(WAIT_TIMEOUT + 1);
  localparam int DW = width_min1(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t    state;
  logic [DW-1:0]  drain_cnt;
  redirect_kind_t kind;
  logic           to_drain;
  logic           hold_mem;
  logic           expired;

  wait_timer #(
    .LIMIT (WAIT_TIMEOUT),
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!hold_mem),
    .enable  (hold_mem),
    .expired (expired)
  );

  always_comb begin
    stall          = '0;
    bubble         = '0;
    nullify        = '0;
    keep_exception = '0;
    pc_stall       = 1'b0;
    redirect_valid = 1'b0;
    kind           = RK_BRANCH;
    timeout_exc    = 1'b0;
    to_drain       = 1'b0;
    hold_mem       = 1'b0;
    if (!reset) begin
      pc_stall = 1'b1;
    end else if (state != DRAIN) begin
      if (exception_req || (mem_wait && expired)) begin
        nullify                   = '1;
        keep_exception[REG_MEMWB] = 1'b1;
        redirect_valid            = 1'b1;
        kind                      = exception_req ? RK_EXCEPTION : RK_TIMEOUT;
        timeout_exc               = !exception_req;
        to_drain                  = 1'b1;
      end else if (eret_req) begin
        // ERET itself sits in MEM/WB and must commit, so that register is left alone.
        nullify[REG_IDEX]  = 1'b1;
        nullify[REG_IFID]  = 1'b1;
        nullify[REG_EXMEM] = 1'b1;
        redirect_valid     = 1'b1;
        kind               = RK_ERET;
        to_drain           = 1'b1;
      end else if (mem_wait) begin
        bubble[REG_EXMEM]  = 1'b1;
        stall[REG_IDEX]    = 1'b1;
        stall[REG_IFID]    = 1'b1;
        nullify[REG_MEMWB] = 1'b1;
        pc_stall           = 1'b1;
        hold_mem           = 1'b1;
      end else if (mdu_busy && mdu_use) begin
        bubble[REG_IDEX]   = 1'b1;
        stall[REG_IFID]    = 1'b1;
        nullify[REG_EXMEM] = 1'b1;
        pc_stall           = 1'b1;
      end else begin
        if (load_use_hazard) begin
          bubble[REG_IFID]  = 1'b1;
          nullify[REG_IDEX] = 1'b1;
          pc_stall          = 1'b1;
        end
        // With a load-use hold, IF/ID keeps the delay slot, so the fetched word is simply dropped.
        if (branch_redirect) begin
          redirect_valid    = 1'b1;
          pc_stall          = 1'b0;
          nullify[REG_IFID] = !load_use_hazard;
        end
      end
    end
  end

  assign redirect_kind = kind;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          drain_cnt <= '0;
          if (to_drain)      state <= DRAIN;
          else if (hold_mem) state <= MEM_WAIT;
          else               state <= RUN;
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= RUN;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: a default-timeout instance and a WAIT_TIMEOUT=4 instance share stimulus.
// Outputs are packed into one word per instance and compared against hand-derived vectors.
module tb_pipeline_hazard_controller;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic load_use_hazard, mdu_busy, mdu_use, mem_wait, branch_redirect, exception_req, eret_req;

  logic [3:0] a_stall, a_bubble, a_nullify, a_keep;
  logic       a_pc_stall, a_rv, a_to;
  logic [1:0] a_kind;
  logic [3:0] b_stall, b_bubble, b_nullify, b_keep;
  logic       b_pc_stall, b_rv, b_to;
  logic [1:0] b_kind;

  localparam logic [6:0] LU = 7'b1000000;
  localparam logic [6:0] MB = 7'b0100000;
  localparam logic [6:0] MU = 7'b0010000;
  localparam logic [6:0] MW = 7'b0001000;
  localparam logic [6:0] BR = 7'b0000100;
  localparam logic [6:0] EX = 7'b0000010;
  localparam logic [6:0] ER = 7'b0000001;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset),
    .load_use_hazard(load_use_hazard), .mdu_busy(mdu_busy), .mdu_use(mdu_use),
    .mem_wait(mem_wait), .branch_redirect(branch_redirect),
    .exception_req(exception_req), .eret_req(eret_req),
    .stall(a_stall), .bubble(a_bubble), .nullify(a_nullify), .keep_exception(a_keep),
    .pc_stall(a_pc_stall), .redirect_valid(a_rv), .redirect_kind(a_kind), .timeout_exc(a_to)
  );

  pipeline_hazard_controller #(.WAIT_TIMEOUT(4), .DRAIN_CYCLES(2)) dut_to (
    .clk(clk), .reset(reset),
    .load_use_hazard(load_use_hazard), .mdu_busy(mdu_busy), .mdu_use(mdu_use),
    .mem_wait(mem_wait), .branch_redirect(branch_redirect),
    .exception_req(exception_req), .eret_req(eret_req),
    .stall(b_stall), .bubble(b_bubble), .nullify(b_nullify), .keep_exception(b_keep),
    .pc_stall(b_pc_stall), .redirect_valid(b_rv), .redirect_kind(b_kind), .timeout_exc(b_to)
  );

  logic [31:0] obs_a, obs_b;
  assign obs_a = {11'b0, a_stall, a_bubble, a_nullify, a_keep, a_pc_stall, a_rv, a_kind, a_to};
  assign obs_b = {11'b0, b_stall, b_bubble, b_nullify, b_keep, b_pc_stall, b_rv, b_kind, b_to};

  function automatic logic [31:0] ov(input logic [3:0] s, input logic [3:0] b,
                                     input logic [3:0] n, input logic [3:0] k,
                                     input logic p, input logic rv,
                                     input logic [1:0] rk, input logic to);
    return {11'b0, s, b, n, k, p, rv, rk, to};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {load_use_hazard, mdu_busy, mdu_use, mem_wait, branch_redirect, exception_req, eret_req} = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] zero_v, rst_v, mw_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_v = ov(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst_v  = ov(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    mw_v   = ov(4'h3, 4'h4, 4'h8, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);

    reset = 1'b0;
    drive(7'b0);
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not leak through.
    drive(LU | EX);
    #1 check("reset_outs", obs_a, rst_v);
    check("reset_outs_to", obs_b, rst_v);
    check("reset_state", 32'(dut.state), 32'(RUN));
    reset = 1'b1;
    drive(7'b0);
    #1 check("idle", obs_a, zero_v);
    tick;

    drive(LU);
    #1 check("load_use", obs_a, ov(4'h0, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0));
    tick;
    drive(7'b0);
    #1 check("load_use_next", obs_a, zero_v);
    tick;

    for (int i = 0; i < 3; i++) begin
      drive(MW);
      #1 check("mem_wait_hold", obs_a, mw_v);
      check("mem_wait_hold_to", obs_b, mw_v);
      tick;
    end
    check("mem_wait_state", 32'(dut.state), 32'(MEM_WAIT));
    drive(7'b0);
    #1 check("mem_wait_release", obs_a, zero_v);
    tick;
    check("mem_wait_back_run", 32'(dut.state), 32'(RUN));
    check("mem_wait_cnt_clear", 32'(dut_to.u_timer.cnt), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(MW);
      #1 check("timeout_pre", obs_b, mw_v);
      tick;
    end
    drive(MW);
    #1 check("timeout_fire", obs_b, ov(4'h0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1, 2'd3, 1'b1));
    check("timeout_big_still_hold", obs_a, mw_v);
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(MW);
      #1 check("timeout_drain", obs_b, zero_v);
      tick;
    end
    drive(MW);
    #1 check("timeout_after_drain", obs_b, mw_v);
    tick;
    drive(7'b0);
    tick;
    tick;

    drive(MW);
    tick;
    drive(MW);
    tick;
    check("exc_pre_cnt", 32'(dut.u_timer.cnt), 32'd2);
    drive(MW | BR | EX);
    #1 check("exc_combo", obs_a, ov(4'h0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1, 2'd1, 1'b0));
    tick;
    check("exc_cnt_clear", 32'(dut.u_timer.cnt), 32'd0);
    check("exc_state_drain", 32'(dut.state), 32'(DRAIN));
    drive(BR | LU | ER);
    #1 check("drain_ignore_1", obs_a, zero_v);
    tick;
    drive(BR);
    #1 check("drain_ignore_2", obs_a, zero_v);
    tick;
    drive(BR);
    #1 check("branch_after_drain", obs_a, ov(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0));
    tick;

    drive(ER);
    #1 check("eret", obs_a, ov(4'h0, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0));
    tick;
    drive(LU);
    #1 check("eret_drain", obs_a, zero_v);
    tick;
    drive(7'b0);
    tick;

    drive(BR | LU);
    #1 check("branch_load_use", obs_a, ov(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0));
    tick;

    for (int i = 0; i < 5; i++) begin
      drive(MB | MU | BR);
      #1 check("mdu_hold_branch", obs_a, ov(4'h1, 4'h2, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0));
      tick;
    end
    drive(MU | BR);
    #1 check("mdu_release_branch", obs_a, ov(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0));
    tick;

    drive(ER | MW | MB | MU);
    #1 check("eret_over_mem_wait", obs_a, ov(4'h0, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0));
    tick;
    drive(7'b0);
    tick;
    tick;

    drive(EX);
    #1 check("exc_before_reset", obs_a, ov(4'h0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1, 2'd1, 1'b0));
    tick;
    drive(LU);
    reset = 1'b0;
    #1 check("reset_in_drain_outs", obs_a, rst_v);
    check("reset_in_drain_state", 32'(dut.state), 32'(RUN));
    reset = 1'b1;
    #1 check("post_reset_load_use", obs_a, ov(4'h0, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0));
    tick;
    drive(7'b0);
    #1 check("post_reset_idle", obs_a, zero_v);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
